dm_sba_ctrl: RTL and testbench

System Bus Access (SBA) controller for the debug module. It implements the sbcs, sbaddress0 and sbdata0 registers behind the DMI register port. It sequences single 32-bit reads and writes onto the core's memory bus master port. Supported triggers are read-on-address, read-on-data, write-on-data and address auto-increment, with error and busy-error reporting per RISC-V Debug Spec 0.13/1.0.

---
 rtl/dm_sba_ctrl_if.sv | 30 +++
 rtl/dm_sba_ctrl.sv | 136 +++++++++++++
 tb/tb_dm_sba_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_sba_ctrl_if.sv
// DMI register port and system-bus master signals of the SBA controller.
interface dm_sba_ctrl_if;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        dmi_wr;
  logic        dmi_rd;
  logic [31:0] dmi_rdata;
  logic        dmi_hit;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport slave (
    input  dmi_addr, dmi_wdata, dmi_wr, dmi_rd,
    output dmi_rdata, dmi_hit,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport master (
    output dmi_addr, dmi_wdata, dmi_wr, dmi_rd,
    input  dmi_rdata, dmi_hit,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/dm_sba_ctrl.sv
// SBA controller: sbcs/sbaddress0/sbdata0 behind the DMI, issuing single 32-bit bus accesses.
// dmi_rdata is registered one cycle after dmi_rd; bus_req follows the BUSY state directly.
module dm_sba_ctrl #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [6:0]  ADDR_SBCS    = 7'h38,
  parameter logic [6:0]  ADDR_SBADDR0 = 7'h39,
  parameter logic [6:0]  ADDR_SBDATA0 = 7'h3C
) (
  input logic          clk,
  input logic          rst,
  input logic          dmactive,
  dm_sba_ctrl_if.slave sba
);
  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic [31:0]   sbaddress0, sbdata0;
  logic [2:0]    sberror, sberror_nxt, sbaccess;
  logic          sbbusyerror, sbbusyerror_nxt;
  logic          readonaddr, readondata, autoincrement;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   rdata_q, addr_q, wdata_q;
  logic          we_q;

  logic        clr, busy, hit_cs, hit_addr, hit_data;
  logic        wr_cs, wr_addr, wr_data, rd_data;
  logic        trig, bad_size, bad_align, start, ack, tmo;
  logic [31:0] trig_addr, sbcs_val;

  assign clr      = rst | ~dmactive;
  assign busy     = (state == BUSY);
  assign hit_cs   = (sba.dmi_addr == ADDR_SBCS);
  assign hit_addr = (sba.dmi_addr == ADDR_SBADDR0);
  assign hit_data = (sba.dmi_addr == ADDR_SBDATA0);
  assign wr_cs    = sba.dmi_wr & hit_cs;
  assign wr_addr  = sba.dmi_wr & hit_addr;
  assign wr_data  = sba.dmi_wr & hit_data;
  assign rd_data  = sba.dmi_rd & hit_data;

  // Triggers fire only from IDLE with no error pending; register updates happen regardless.
  assign trig      = ~busy && (sberror == 3'd0) && ~sbbusyerror &&
                     ((wr_addr && readonaddr) || wr_data || (rd_data && readondata));
  assign trig_addr = wr_addr ? sba.dmi_wdata : sbaddress0;
  assign bad_size  = (sbaccess != 3'd2);
  assign bad_align = (trig_addr[1:0] != 2'b00);
  assign start     = trig & ~bad_size & ~bad_align;
  assign ack       = busy & sba.bus_ack;
  assign tmo       = busy & ~sba.bus_ack & (tmo_cnt == TMO_LAST);

  assign sbcs_val = {3'd1, 6'd0, sbbusyerror, busy, readonaddr, sbaccess, autoincrement,
                     readondata, sberror, 7'd32, 2'b00, 1'b1, 2'b00};

  assign sba.dmi_hit   = hit_cs | hit_addr | hit_data;
  assign sba.dmi_rdata = rdata_q;
  assign sba.bus_req   = busy;
  assign sba.bus_we    = we_q;
  assign sba.bus_addr  = addr_q;
  assign sba.bus_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (ack || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // W1C is applied first so that an error raised in the same cycle survives the clear.
  always_comb begin
    sberror_nxt     = sberror;
    sbbusyerror_nxt = sbbusyerror;
    if (wr_cs) begin
      sberror_nxt = sberror & ~sba.dmi_wdata[14:12];
      if (sba.dmi_wdata[22]) sbbusyerror_nxt = 1'b0;
    end
    if (trig && bad_size)           sberror_nxt = 3'd4;
    else if (trig && bad_align)     sberror_nxt = 3'd3;
    else if (ack && sba.bus_err)    sberror_nxt = 3'd2;
    else if (tmo)                   sberror_nxt = 3'd1;
    if (busy && (wr_addr || wr_data || rd_data)) sbbusyerror_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sbaddress0    <= '0;
      sbdata0       <= '0;
      sberror       <= '0;
      sbbusyerror   <= 1'b0;
      readonaddr    <= 1'b0;
      readondata    <= 1'b0;
      autoincrement <= 1'b0;
      sbaccess      <= 3'd2;
      tmo_cnt       <= '0;
      rdata_q       <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      sberror     <= sberror_nxt;
      sbbusyerror <= sbbusyerror_nxt;
      if (sba.dmi_rd)
        rdata_q <= hit_cs ? sbcs_val : hit_addr ? sbaddress0 : hit_data ? sbdata0 : 32'd0;
      if (wr_cs) begin
        readonaddr    <= sba.dmi_wdata[20];
        sbaccess      <= sba.dmi_wdata[19:17];
        autoincrement <= sba.dmi_wdata[16];
        readondata    <= sba.dmi_wdata[15];
      end
      if (wr_addr && !busy)
        sbaddress0 <= sba.dmi_wdata;
      else if (ack && !sba.bus_err && autoincrement)
        sbaddress0 <= sbaddress0 + 32'd4;
      if (wr_data && !busy)
        sbdata0 <= sba.dmi_wdata;
      else if (ack && !sba.bus_err && !we_q)
        sbdata0 <= sba.bus_rdata;
      if (start) begin
        we_q    <= wr_data;
        addr_q  <= trig_addr;
        wdata_q <= wr_data ? sba.dmi_wdata : sbdata0;
        tmo_cnt <= '0;
      end else if (busy && !ack && !tmo) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Bench for dm_sba_ctrl: directed plan steps plus random DMI traffic against a register-level model.
module tb_dm_sba_ctrl;
  localparam int unsigned TMO  = 8;
  localparam logic [6:0]  A_CS = 7'h38;
  localparam logic [6:0]  A_AD = 7'h39;
  localparam logic [6:0]  A_DA = 7'h3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dmactive = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dm_sba_ctrl_if sba();
  dm_sba_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .dmactive(dmactive), .sba(sba));

  always #5 clk = ~clk;

  // Reference model: architectural register contents plus the access expected on the bus.
  logic [31:0] m_addr, m_data;
  logic [2:0]  m_err, m_access;
  logic        m_berr, m_roa, m_rod, m_ainc;
  logic        exp_acc, exp_we;
  logic [31:0] exp_addr, exp_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_sbcs(input logic busy);
    return {3'd1, 6'd0, m_berr, busy, m_roa, m_access, m_ainc, m_rod, m_err, 7'd32, 2'd0, 1'b1, 2'd0};
  endfunction

  function automatic logic [31:0] mk_cs(input logic roa, input logic [2:0] acc, input logic ainc,
                                        input logic rod, input logic w1c);
    return {9'd0, w1c, 1'b0, roa, acc, ainc, rod, {3{w1c}}, 12'd0};
  endfunction

  task automatic m_reset();
    m_addr = '0; m_data = '0; m_err = '0; m_berr = 1'b0;
    m_roa = 1'b0; m_rod = 1'b0; m_ainc = 1'b0; m_access = 3'd2;
  endtask

  task automatic m_cs_write(input logic [31:0] v);
    if (v[22]) m_berr = 1'b0;
    m_err    = m_err & ~v[14:12];
    m_roa    = v[20];
    m_access = v[19:17];
    m_ainc   = v[16];
    m_rod    = v[15];
  endtask

  // Called at a negedge; returns at the next negedge with the strobe removed.
  task automatic dmi_cycle(input bit wr, input logic [6:0] a, input logic [31:0] d);
    sba.dmi_addr = a; sba.dmi_wdata = d; sba.dmi_wr = wr; sba.dmi_rd = !wr;
    @(negedge clk);
    sba.dmi_wr = 1'b0; sba.dmi_rd = 1'b0;
  endtask

  // kind: 0 wr sbcs, 1 wr sbaddress0, 2 wr sbdata0, 3 rd sbdata0, 4 rd sbaddress0, 5 rd sbcs
  task automatic op(input int kind, input logic [31:0] v, input bit busy_now);
    logic [31:0] exp_rd, a;
    logic [6:0]  ra;
    bit          trig;
    exp_rd  = '0;
    exp_acc = 1'b0;
    ra = (kind == 0 || kind == 5) ? A_CS : (kind == 1 || kind == 4) ? A_AD : A_DA;
    case (kind)
      3: exp_rd = m_data;
      4: exp_rd = m_addr;
      5: exp_rd = m_sbcs(busy_now);
      default: ;
    endcase
    if (busy_now) begin
      if (kind >= 1 && kind <= 3) m_berr = 1'b1;
      if (kind == 0) m_cs_write(v);
    end else begin
      trig = (m_err == 3'd0) && !m_berr && ((kind == 1 && m_roa) || kind == 2 || (kind == 3 && m_rod));
      a = (kind == 1) ? v : m_addr;
      if (kind == 0) m_cs_write(v);
      if (kind == 1) m_addr = v;
      if (kind == 2) m_data = v;
      if (trig) begin
        if (m_access != 3'd2)  m_err = 3'd4;
        else if (a % 4 != 0)   m_err = 3'd3;
        else begin
          exp_acc = 1'b1; exp_we = (kind == 2); exp_addr = a; exp_wdata = v;
        end
      end
    end
    dmi_cycle(kind <= 2, ra, v);
    if (kind >= 3) chk("dmi_rdata", sba.dmi_rdata, exp_rd);
    if (!busy_now) begin
      chk("bus_req", 32'(sba.bus_req), 32'(exp_acc));
      if (exp_acc) begin
        chk("bus_we", 32'(sba.bus_we), 32'(exp_we));
        chk("bus_addr", sba.bus_addr, exp_addr);
        if (exp_we) chk("bus_wdata", sba.bus_wdata, exp_wdata);
      end
    end
  endtask

  // Hold off the ack for 'waits' cycles, then complete; optionally W1C sbcs in the ack cycle.
  task automatic finish(input int waits, input logic [31:0] rd, input bit err, input bit w1c);
    logic [31:0] csv;
    csv = mk_cs(m_roa, m_access, m_ainc, m_rod, 1'b1);
    for (int i = 0; i < waits; i++) begin
      chk("hold_req", 32'(sba.bus_req), 32'd1);
      chk("hold_addr", sba.bus_addr, exp_addr);
      @(negedge clk);
    end
    sba.bus_ack = 1'b1; sba.bus_err = err; sba.bus_rdata = rd;
    if (w1c) begin
      sba.dmi_addr = A_CS; sba.dmi_wdata = csv; sba.dmi_wr = 1'b1;
    end
    @(negedge clk);
    sba.bus_ack = 1'b0; sba.bus_err = 1'b0; sba.dmi_wr = 1'b0;
    if (w1c) m_cs_write(csv);
    if (err) m_err = 3'd2;
    else begin
      if (!exp_we) m_data = rd;
      if (m_ainc) m_addr = m_addr + 32'd4;
    end
    chk("req_drop", 32'(sba.bus_req), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  hit_tab [6];
    logic [31:0] v;
    int          n, kind;
    hit_tab = '{7'h38, 7'h39, 7'h3C, 7'h3A, 7'h3B, 7'h00};
    sba.dmi_addr = '0; sba.dmi_wdata = '0; sba.dmi_wr = 1'b0; sba.dmi_rd = 1'b0;
    sba.bus_ack = 1'b0; sba.bus_err = 1'b0; sba.bus_rdata = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_req", 32'(sba.bus_req), 32'd0);
    chk("rst_we", 32'(sba.bus_we), 32'd0);
    chk("rst_addr", sba.bus_addr, 32'd0);
    chk("rst_wdata", sba.bus_wdata, 32'd0);
    chk("rst_rdata", sba.dmi_rdata, 32'd0);
    op(5, 32'd0, 1'b0);
    dmi_cycle(1'b0, 7'h3B, 32'd0);
    chk("unmapped_rd", sba.dmi_rdata, 32'd0);
    for (int i = 0; i < 6; i++) begin
      sba.dmi_addr = hit_tab[i];
      #1;
      chk("dmi_hit", 32'(sba.dmi_hit),
          32'(hit_tab[i] == A_CS || hit_tab[i] == A_AD || hit_tab[i] == A_DA));
    end
    @(negedge clk);

    // Write-on-data
    op(1, 32'h8000_0010, 1'b0);
    op(2, 32'hDEAD_BEEF, 1'b0);
    finish(3, 32'd0, 1'b0, 1'b0);
    op(5, 32'd0, 1'b0);

    // Read-on-address with autoincrement
    op(0, mk_cs(1'b1, 3'd2, 1'b1, 1'b0, 1'b0), 1'b0);
    op(1, 32'h0000_0100, 1'b0);
    finish(2, 32'h1234_5678, 1'b0, 1'b0);
    op(3, 32'd0, 1'b0);
    op(4, 32'd0, 1'b0);

    // Read-on-data streaming
    op(0, mk_cs(1'b0, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0);
    op(1, 32'h0000_0200, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op(3, 32'd0, 1'b0);
      finish(int'($urandom_range(0, 3)), $urandom, 1'b0, 1'b0);
    end
    op(0, mk_cs(1'b0, 3'd2, 1'b1, 1'b0, 1'b0), 1'b0);
    op(3, 32'd0, 1'b0);
    op(4, 32'd0, 1'b0);

    // Busy error
    op(0, mk_cs(1'b0, 3'd2, 1'b0, 1'b0, 1'b0), 1'b0);
    op(1, 32'h0000_0300, 1'b0);
    op(2, 32'hA5A5_A5A5, 1'b0);
    op(2, 32'h5A5A_5A5A, 1'b1);
    chk("busy_wdata", sba.bus_wdata, exp_wdata);
    op(5, 32'd0, 1'b1);
    finish(2, 32'd0, 1'b0, 1'b0);
    op(3, 32'd0, 1'b0);
    op(2, 32'h1111_1111, 1'b0);
    op(0, mk_cs(1'b0, 3'd2, 1'b0, 1'b0, 1'b1), 1'b0);
    op(2, 32'h2222_2222, 1'b0);
    finish(1, 32'd0, 1'b0, 1'b0);
    op(5, 32'd0, 1'b0);

    // Size error, alignment error on a new address
    op(0, mk_cs(1'b0, 3'd1, 1'b0, 1'b0, 1'b0), 1'b0);
    op(2, 32'h3333_3333, 1'b0);
    op(5, 32'd0, 1'b0);
    op(0, mk_cs(1'b1, 3'd2, 1'b0, 1'b0, 1'b1), 1'b0);
    op(1, 32'h0000_0102, 1'b0);
    op(5, 32'd0, 1'b0);

    // Bus error with a W1C of sberror in the same cycle: the set wins, no increment
    op(0, mk_cs(1'b0, 3'd2, 1'b1, 1'b0, 1'b1), 1'b0);
    op(1, 32'h0000_0400, 1'b0);
    op(2, 32'h4444_4444, 1'b0);
    finish(1, 32'd0, 1'b1, 1'b1);
    op(5, 32'd0, 1'b0);
    op(4, 32'd0, 1'b0);

    // Timeout
    op(0, mk_cs(1'b0, 3'd2, 1'b1, 1'b0, 1'b1), 1'b0);
    op(2, 32'hC0FF_EE00, 1'b0);
    n = 0;
    while (sba.bus_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_len", 32'(n >= int'(TMO) && n <= int'(TMO) + 1), 32'd1);
    m_err = 3'd1;
    op(5, 32'd0, 1'b0);
    op(4, 32'd0, 1'b0);

    // Address wrap on autoincrement
    op(0, mk_cs(1'b1, 3'd2, 1'b1, 1'b0, 1'b1), 1'b0);
    op(1, 32'hFFFF_FFFC, 1'b0);
    finish(0, 32'h5555_AAAA, 1'b0, 1'b0);
    op(4, 32'd0, 1'b0);

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 4));
      v = $urandom;
      if (kind == 0)
        v = mk_cs(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (kind == 1 && $urandom_range(0, 5) != 0)
        v[1:0] = 2'b00;
      op(kind, v, 1'b0);
      if (exp_acc)
        finish(int'($urandom_range(0, 4)), $urandom, ($urandom_range(0, 7) == 0), 1'b0);
      if ($urandom_range(0, 2) == 0) op(5, 32'd0, 1'b0);
    end

    // Reset mid-access via rst, then via dmactive; a late ack must be ignored
    for (int r = 0; r < 2; r++) begin
      op(0, mk_cs(1'b0, 3'd2, 1'b1, 1'b0, 1'b1), 1'b0);
      op(1, 32'h0000_0500, 1'b0);
      op(2, 32'h7777_0000 + 32'(r), 1'b0);
      if (r == 0) rst = 1'b1;
      else        dmactive = 1'b0;
      @(negedge clk);
      rst = 1'b0; dmactive = 1'b1;
      m_reset();
      chk("mid_rst_req", 32'(sba.bus_req), 32'd0);
      chk("mid_rst_we", 32'(sba.bus_we), 32'd0);
      chk("mid_rst_addr", sba.bus_addr, 32'd0);
      chk("mid_rst_wdata", sba.bus_wdata, 32'd0);
      chk("mid_rst_rdata", sba.dmi_rdata, 32'd0);
      sba.bus_ack = 1'b1; sba.bus_err = 1'b1; sba.bus_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      sba.bus_ack = 1'b0; sba.bus_err = 1'b0;
      chk("late_ack_req", 32'(sba.bus_req), 32'd0);
      op(5, 32'd0, 1'b0);
      op(4, 32'd0, 1'b0);
      op(3, 32'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
